// File: rtl/spi_register_writer.sv
// SPI mode-0 master that sends {write flag, register, value} frames to the synth's register-write slave
// and returns the 16-bit sample the synth shifts back on MISO during the first half of each frame.
module spi_register_writer #(
   parameter int CLKS_PER_HALF_BIT = 2,
   parameter int GAP_CLKS          = 4
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic        i_CmdValid,
   output logic        o_CmdReady,
   input  logic [14:0] i_CmdRegister,
   input  logic [15:0] i_CmdValue,
   output logic        o_ReadValid,
   output logic [15:0] o_ReadSample,
   output logic        o_Busy,
   output logic        o_SPI_SCK,
   output logic        o_SPI_MOSI,
   input  logic        i_SPI_MISO
);

   localparam int HALF_W = $clog2(CLKS_PER_HALF_BIT) + 1;
   localparam int GAP_W  = $clog2(GAP_CLKS) + 1;
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLKS_PER_HALF_BIT - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CLKS - 1);
   localparam logic [5:0]        BIT_LAST  = 6'd31;

   typedef enum logic [1:0] {
      IDLE,
      SCK_LOW,
      SCK_HIGH,
      GAP
   } state_t;

   state_t             state_q;
   logic [HALF_W-1:0]  halfCnt_q;
   logic [5:0]         bitCnt_q;
   logic [GAP_W-1:0]   gapCnt_q;
   logic [30:0]        txShift_q;
   logic [15:0]        rxShift_q;
   logic [15:0]        rxShift_d;
   logic [15:0]        readSample_q;
   logic               cmdReady_q;
   logic               readValid_q;
   logic               busy_q;
   logic               sck_q;
   logic               mosi_q;

   // Only the first 16 MISO bits carry the sample, so the receive register stops shifting after bit 15.
   assign rxShift_d = {rxShift_q[14:0], i_SPI_MISO};

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q      <= IDLE;
         halfCnt_q    <= '0;
         bitCnt_q     <= '0;
         gapCnt_q     <= '0;
         txShift_q    <= '0;
         rxShift_q    <= '0;
         readSample_q <= '0;
         cmdReady_q   <= 1'b0;
         readValid_q  <= 1'b0;
         busy_q       <= 1'b0;
         sck_q        <= 1'b0;
         mosi_q       <= 1'b0;
      end else begin
         readValid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cmdReady_q && i_CmdValid) begin
                  txShift_q  <= {i_CmdRegister, i_CmdValue};
                  mosi_q     <= 1'b1;
                  halfCnt_q  <= '0;
                  bitCnt_q   <= '0;
                  busy_q     <= 1'b1;
                  cmdReady_q <= 1'b0;
                  state_q    <= SCK_LOW;
               end else begin
                  cmdReady_q <= 1'b1;
               end
            end
            SCK_LOW: begin
               if (halfCnt_q == HALF_LAST) begin
                  halfCnt_q <= '0;
                  sck_q     <= 1'b1;
                  state_q   <= SCK_HIGH;
               end else begin
                  halfCnt_q <= halfCnt_q + HALF_W'(1);
               end
            end
            SCK_HIGH: begin
               if (halfCnt_q == HALF_LAST) begin
                  halfCnt_q <= '0;
                  sck_q     <= 1'b0;
                  if (bitCnt_q[5:4] == 2'b00) begin
                     rxShift_q <= rxShift_d;
                  end
                  if (bitCnt_q == BIT_LAST) begin
                     mosi_q       <= 1'b0;
                     readValid_q  <= 1'b1;
                     readSample_q <= rxShift_q;
                     gapCnt_q     <= '0;
                     state_q      <= GAP;
                  end else begin
                     bitCnt_q  <= bitCnt_q + 6'd1;
                     mosi_q    <= txShift_q[30];
                     txShift_q <= {txShift_q[29:0], 1'b0};
                     state_q   <= SCK_LOW;
                  end
               end else begin
                  halfCnt_q <= halfCnt_q + HALF_W'(1);
               end
            end
            GAP: begin
               if (gapCnt_q == GAP_LAST) begin
                  busy_q     <= 1'b0;
                  cmdReady_q <= 1'b1;
                  state_q    <= IDLE;
               end else begin
                  gapCnt_q <= gapCnt_q + GAP_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_CmdReady   = cmdReady_q;
   assign o_ReadValid  = readValid_q;
   assign o_ReadSample = readSample_q;
   assign o_Busy       = busy_q;
   assign o_SPI_SCK    = sck_q;
   assign o_SPI_MOSI   = mosi_q;

endmodule

// File: tb/tb_spi_register_writer.sv
// Directed bench for spi_register_writer: two instances (H=2/GAP=4 and H=1/GAP=2) each talking to a
// behavioural synth-side SPI slave that captures frames and returns a fixed MISO word.
module tb_spi_register_writer;

   logic        clk;
   logic        rst;
   logic        cmdValid   [2];
   logic [14:0] cmdReg     [2];
   logic [15:0] cmdVal     [2];
   logic        cmdReady   [2];
   logic        readValid  [2];
   logic [15:0] readSample [2];
   logic        busy       [2];
   logic        sck        [2];
   logic        mosi       [2];
   logic        miso       [2];
   logic [31:0] misoWord   [2];
   logic [31:0] frameLog   [2][8];
   int          frameCount [2];
   int          checks   = 0;
   int          failures = 0;

   spi_register_writer #(.CLKS_PER_HALF_BIT(2), .GAP_CLKS(4)) dut (
      .i_Clock(clk), .i_Reset(rst),
      .i_CmdValid(cmdValid[0]), .o_CmdReady(cmdReady[0]),
      .i_CmdRegister(cmdReg[0]), .i_CmdValue(cmdVal[0]),
      .o_ReadValid(readValid[0]), .o_ReadSample(readSample[0]), .o_Busy(busy[0]),
      .o_SPI_SCK(sck[0]), .o_SPI_MOSI(mosi[0]), .i_SPI_MISO(miso[0])
   );

   spi_register_writer #(.CLKS_PER_HALF_BIT(1), .GAP_CLKS(2)) dutFast (
      .i_Clock(clk), .i_Reset(rst),
      .i_CmdValid(cmdValid[1]), .o_CmdReady(cmdReady[1]),
      .i_CmdRegister(cmdReg[1]), .i_CmdValue(cmdVal[1]),
      .o_ReadValid(readValid[1]), .o_ReadSample(readSample[1]), .o_Busy(busy[1]),
      .o_SPI_SCK(sck[1]), .o_SPI_MOSI(mosi[1]), .i_SPI_MISO(miso[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Presents a command and returns just after the edge that accepted it, leaving i_CmdValid high.
   task automatic applyStimulus(input int g, input logic [14:0] r, input logic [15:0] v);
      bit ok;
      ok = 1'b0;
      cmdValid[g] = 1'b1;
      cmdReg[g]   = r;
      cmdVal[g]   = v;
      for (int i = 0; i < 1000 && !ok; i++) begin
         if (cmdReady[g]) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      checkOutput("cmdAccepted", 32'(ok), 32'd1);
   endtask

   task automatic waitReadValid(input int g, output int n);
      n = 0;
      while (!readValid[g] && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic waitReady(input int g, inout int n);
      int limit;
      limit = n + 1000;
      while (!cmdReady[g] && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   // Synth-side slave model plus protocol monitor, evaluated on the falling clock edge.
   for (genvar g = 0; g < 2; g++) begin : gSlave
      localparam int H = (g == 0) ? 2 : 1;
      logic        sckPrev  = 1'b0;
      logic        mosiPrev = 1'b0;
      logic        busyPrev = 1'b0;
      logic [4:0]  fallBit  = 5'd0;
      logic [31:0] shiftIn  = 32'd0;
      int          rise     = 0;
      int          highRun  = 0;
      int          lowRun   = 0;
      bit          aborted  = 1'b0;

      assign miso[g] = misoWord[g][5'd31 - fallBit];

      initial begin
         forever begin
            @(negedge clk);
            if (rst) begin
               fallBit = 5'd0;
               rise    = 0;
               aborted = 1'b1;
            end else begin
               if (busy[g] && !busyPrev) aborted = 1'b0;
               if (!busy[g]) begin
                  checkOutput("sckIdleLow", 32'(sck[g]), 32'd0);
                  checkOutput("mosiIdleLow", 32'(mosi[g]), 32'd0);
               end
               if (readValid[g]) checkOutput("sckLowAtFrameEnd", 32'(sck[g]), 32'd0);
               if (sck[g] && sckPrev) checkOutput("mosiStableHigh", 32'(mosi[g]), 32'(mosiPrev));
               if (sck[g] && !sckPrev) begin
                  checkOutput("sckLowHalf", 32'(lowRun), 32'(H));
                  highRun = 1;
                  shiftIn = {shiftIn[30:0], mosi[g]};
                  rise++;
                  if (rise == 32) begin
                     frameLog[g][frameCount[g] % 8] = shiftIn;
                     frameCount[g]++;
                     rise = 0;
                  end
               end else if (sck[g]) begin
                  highRun++;
               end else if (sckPrev) begin
                  if (!aborted) begin
                     checkOutput("sckHighHalf", 32'(highRun), 32'(H));
                     fallBit = fallBit + 5'd1;
                  end
                  aborted = 1'b0;
                  lowRun  = 1;
               end else if (busy[g] && !busyPrev) begin
                  lowRun = 1;
               end else begin
                  lowRun++;
               end
            end
            sckPrev  = sck[g];
            mosiPrev = mosi[g];
            busyPrev = busy[g];
         end
      end
   end

   initial begin
      int n;
      int r;
      int gapCnt;
      int pulses;
      int fc;
      logic prev;

      rst = 1'b1;
      for (int g = 0; g < 2; g++) begin
         cmdValid[g]   = 1'b0;
         cmdReg[g]     = '0;
         cmdVal[g]     = '0;
         frameCount[g] = 0;
      end
      misoWord[0] = 32'h8001_FFFF;
      misoWord[1] = 32'h0000_0000;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetReady", 32'(cmdReady[0]), 32'd0);
      checkOutput("resetSck", 32'(sck[0]), 32'd0);
      checkOutput("resetMosi", 32'(mosi[0]), 32'd0);
      checkOutput("resetBusy", 32'(busy[0]), 32'd0);
      checkOutput("resetReadValid", 32'(readValid[0]), 32'd0);
      checkOutput("resetSample", 32'(readSample[0]), 32'd0);
      checkOutput("resetReadyFast", 32'(cmdReady[1]), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("readyAfterReset", 32'(cmdReady[0]), 32'd1);

      $display("[TB] single frame reg=0x4012 value=0xBEEF");
      fc = frameCount[0];
      applyStimulus(0, 15'h4012, 16'hBEEF);
      cmdValid[0] = 1'b0;
      checkOutput("firstCycleSck", 32'(sck[0]), 32'd0);
      checkOutput("firstCycleMosi", 32'(mosi[0]), 32'd1);
      checkOutput("firstCycleBusy", 32'(busy[0]), 32'd1);
      checkOutput("firstCycleReady", 32'(cmdReady[0]), 32'd0);
      waitReadValid(0, n);
      checkOutput("readValidLatency", 32'(n), 32'd128);
      checkOutput("readSample", 32'(readSample[0]), 32'h8001);
      checkOutput("frameCount1", 32'(frameCount[0] - fc), 32'd1);
      checkOutput("mosiStream", frameLog[0][fc % 8], 32'hC012_BEEF);
      @(posedge clk);
      #1;
      n++;
      checkOutput("readValidOneCycle", 32'(readValid[0]), 32'd0);
      checkOutput("gapBusy", 32'(busy[0]), 32'd1);
      waitReady(0, n);
      checkOutput("readyLatency", 32'(n), 32'd132);
      checkOutput("sampleHeld", 32'(readSample[0]), 32'h8001);

      $display("[TB] two queued commands with valid held high");
      fc = frameCount[0];
      applyStimulus(0, 15'h0000, 16'h0001);
      cmdReg[0] = 15'h0100;
      cmdVal[0] = 16'h1234;
      waitReadValid(0, n);
      checkOutput("queuedLatency1", 32'(n), 32'd128);
      gapCnt = 0;
      for (int m = 0; m < 50 && !cmdReady[0]; m++) begin
         if (busy[0] && !sck[0] && !mosi[0]) gapCnt++;
         @(posedge clk);
         #1;
      end
      checkOutput("gapCycles", 32'(gapCnt), 32'd4);
      @(posedge clk);
      #1;
      cmdValid[0] = 1'b0;
      checkOutput("secondAcceptBusy", 32'(busy[0]), 32'd1);
      waitReadValid(0, n);
      checkOutput("queuedLatency2", 32'(n), 32'd128);
      repeat (300) @(posedge clk);
      #1;
      checkOutput("queuedFrameCount", 32'(frameCount[0] - fc), 32'd2);
      checkOutput("queuedFrame1", frameLog[0][fc % 8], 32'h8000_0001);
      checkOutput("queuedFrame2", frameLog[0][(fc + 1) % 8], 32'h8100_1234);

      $display("[TB] reset at SCK rising edge 10");
      fc = frameCount[0];
      applyStimulus(0, 15'h2AAA, 16'h5555);
      cmdValid[0] = 1'b0;
      r    = 0;
      prev = sck[0];
      for (int m = 0; m < 200 && r < 10; m++) begin
         @(posedge clk);
         #1;
         if (sck[0] && !prev) r++;
         prev = sck[0];
      end
      checkOutput("risingEdgesBeforeReset", 32'(r), 32'd10);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abortSck", 32'(sck[0]), 32'd0);
      checkOutput("abortMosi", 32'(mosi[0]), 32'd0);
      checkOutput("abortBusy", 32'(busy[0]), 32'd0);
      checkOutput("abortReadValid", 32'(readValid[0]), 32'd0);
      checkOutput("abortSample", 32'(readSample[0]), 32'd0);
      rst = 1'b0;
      pulses = 0;
      for (int m = 0; m < 20; m++) begin
         @(posedge clk);
         #1;
         if (readValid[0]) pulses++;
      end
      checkOutput("noPartialReadValid", 32'(pulses), 32'd0);
      checkOutput("noPartialFrame", 32'(frameCount[0] - fc), 32'd0);
      applyStimulus(0, 15'h0005, 16'h00A5);
      cmdValid[0] = 1'b0;
      waitReadValid(0, n);
      checkOutput("postResetLatency", 32'(n), 32'd128);
      checkOutput("postResetFrame", frameLog[0][fc % 8], 32'h8005_00A5);
      checkOutput("postResetSample", 32'(readSample[0]), 32'h8001);

      $display("[TB] H=1 GAP=2 back-to-back note-on writes");
      fc = frameCount[1];
      applyStimulus(1, 15'h0000, 16'h0001);
      cmdVal[1] = 16'h0003;
      waitReadValid(1, n);
      checkOutput("fastLatency1", 32'(n), 32'd64);
      gapCnt = 0;
      for (int m = 0; m < 50 && !cmdReady[1]; m++) begin
         if (busy[1] && !sck[1] && !mosi[1]) gapCnt++;
         @(posedge clk);
         #1;
      end
      checkOutput("fastGapCycles", 32'(gapCnt), 32'd2);
      @(posedge clk);
      #1;
      cmdValid[1] = 1'b0;
      waitReadValid(1, n);
      checkOutput("fastLatency2", 32'(n), 32'd64);
      checkOutput("fastSample", 32'(readSample[1]), 32'h0000);
      repeat (100) @(posedge clk);
      #1;
      checkOutput("fastWriteEdges", 32'(frameCount[1] - fc), 32'd2);
      checkOutput("fastFrame1", frameLog[1][fc % 8], 32'h8000_0001);
      checkOutput("fastFrame2", frameLog[1][(fc + 1) % 8], 32'h8000_0003);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
